// File: rtl/countdown_timer.sv
// BCD countdown timer (dd.d seconds) for timed typing rounds; shares the stopwatch display path.
// Optional low-time warning output enabled by defining COUNTDOWN_WARN_EN.
module countdown_timer #(
   parameter int unsigned TICK_DIV     = 10_000_000,
   parameter int unsigned RESET_DECA   = 6,
   parameter int unsigned RESET_SEC    = 0,
   parameter int unsigned RESET_DECI   = 0,
   parameter int unsigned WARN_SECONDS = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] preset_decaseconds,
   input  logic [3:0] preset_seconds,
   input  logic [3:0] preset_deciseconds,
   input  logic       start,
   output logic [3:0] deciseconds_out,
   output logic [3:0] seconds_out,
   output logic [3:0] decaseconds_out,
   output logic       running,
   output logic       at_zero,
   output logic       done_pulse,
   output logic       warn
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0] R_DECA = 4'(RESET_DECA);
   localparam logic [3:0] R_SEC  = 4'(RESET_SEC);
   localparam logic [3:0] R_DECI = 4'(RESET_DECI);
   localparam logic RESET_ZERO = (RESET_DECA == 0) && (RESET_SEC == 0) && (RESET_DECI == 0);

   typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

   localparam state_t RESET_STATE = RESET_ZERO ? EXPIRED : IDLE;

   // Elaboration-time guard on parameter ranges
   if (TICK_DIV < 2 || RESET_DECA > 9 || RESET_SEC > 9 || RESET_DECI > 9 ||
       WARN_SECONDS < 1 || WARN_SECONDS > 9) begin : g_bad_param
      $error("countdown_timer: parameter out of range");
   end

   state_t          state, state_nxt;
   logic [PW-1:0]   presc, presc_nxt;
   logic [3:0]      deca_nxt, sec_nxt, deci_nxt;
   logic [3:0]      clamp_deca, clamp_sec, clamp_deci;
   logic            done_nxt;
   logic            cur_zero, nxt_zero;

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign clamp_deca = clamp9(preset_decaseconds);
   assign clamp_sec  = clamp9(preset_seconds);
   assign clamp_deci = clamp9(preset_deciseconds);
   assign cur_zero   = (decaseconds_out == 4'd0) && (seconds_out == 4'd0) && (deciseconds_out == 4'd0);
   assign nxt_zero   = (deca_nxt == 4'd0) && (sec_nxt == 4'd0) && (deci_nxt == 4'd0);

   always_ff @(posedge clk) begin
      if (rst) state <= RESET_STATE;
      else     state <= state_nxt;
   end

   // Next state, next digits and prescaler
   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      deca_nxt  = decaseconds_out;
      sec_nxt   = seconds_out;
      deci_nxt  = deciseconds_out;
      done_nxt  = 1'b0;
      if (load) begin
         deca_nxt  = clamp_deca;
         sec_nxt   = clamp_sec;
         deci_nxt  = clamp_deci;
         presc_nxt = '0;
         state_nxt = (clamp_deca == 4'd0 && clamp_sec == 4'd0 && clamp_deci == 4'd0) ? EXPIRED : IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start && !cur_zero) state_nxt = RUN;
            end
            RUN: begin
               if (!start) begin
                  state_nxt = IDLE;
               end else if (presc == TICK_LAST) begin
                  presc_nxt = '0;
                  if (!cur_zero) begin
                     if (deciseconds_out != 4'd0) begin
                        deci_nxt = deciseconds_out - 4'd1;
                     end else begin
                        deci_nxt = 4'd9;
                        if (seconds_out != 4'd0) begin
                           sec_nxt = seconds_out - 4'd1;
                        end else begin
                           sec_nxt  = 4'd9;
                           deca_nxt = decaseconds_out - 4'd1;
                        end
                     end
                  end
                  if ((deca_nxt == 4'd0) && (sec_nxt == 4'd0) && (deci_nxt == 4'd0)) begin
                     state_nxt = EXPIRED;
                     done_nxt  = !cur_zero;
                  end
               end else begin
                  presc_nxt = presc + PW'(1);
               end
            end
            EXPIRED: begin
               state_nxt = EXPIRED;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         decaseconds_out <= R_DECA;
         seconds_out     <= R_SEC;
         deciseconds_out <= R_DECI;
         presc           <= '0;
         running         <= 1'b0;
         at_zero         <= RESET_ZERO;
         done_pulse      <= 1'b0;
      end else begin
         decaseconds_out <= deca_nxt;
         seconds_out     <= sec_nxt;
         deciseconds_out <= deci_nxt;
         presc           <= presc_nxt;
         running         <= (state_nxt == RUN);
         at_zero         <= nxt_zero;
         done_pulse      <= done_nxt;
      end
   end

`ifdef COUNTDOWN_WARN_EN
   localparam logic [3:0] WARN_SEC = 4'(WARN_SECONDS);
   logic warn_nxt;

   // Warning window is 0 < value <= WARN_SECONDS.0, evaluated on the incoming digits
   assign warn_nxt = !nxt_zero && (deca_nxt == 4'd0) &&
                     ((sec_nxt < WARN_SEC) || ((sec_nxt == WARN_SEC) && (deci_nxt == 4'd0)));

   always_ff @(posedge clk) begin
      if (rst) warn <= 1'b0;
      else     warn <= warn_nxt;
   end
`else
   assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4; warn expectations follow COUNTDOWN_WARN_EN.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst, load, start;
   logic [3:0] p_deca, p_sec, p_deci;
   logic [3:0] deci, sec, deca;
   logic       running, at_zero, done_pulse, warn;

   int n_checks = 0;
   int n_fail   = 0;

   countdown_timer #(
      .TICK_DIV(4), .RESET_DECA(6), .RESET_SEC(0), .RESET_DECI(0), .WARN_SECONDS(5)
   ) dut (
      .clk(clk), .rst(rst), .load(load),
      .preset_decaseconds(p_deca), .preset_seconds(p_sec), .preset_deciseconds(p_deci),
      .start(start),
      .deciseconds_out(deci), .seconds_out(sec), .decaseconds_out(deca),
      .running(running), .at_zero(at_zero), .done_pulse(done_pulse), .warn(warn)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [11:0] exp);
      check(tag, 32'({deca, sec, deci}), 32'(exp));
   endtask

   task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      load = 1'b1; p_deca = a; p_sec = b; p_deci = c;
      step(1);
      load = 1'b0;
   endtask

   initial begin
      logic warn_exp;
      logic [11:0] v;
      rst = 1'b1; load = 1'b0; start = 1'b0; p_deca = '0; p_sec = '0; p_deci = '0;
      step(2);
      rst = 1'b0;
      check_val("reset_val", 12'h600);
      check("reset_at_zero", 32'(at_zero), 0);
      check("reset_running", 32'(running), 0);
      check("reset_warn", 32'(warn), 0);
      check("reset_done", 32'(done_pulse), 0);

      // Borrow chain 60.0 -> 59.9
      start = 1'b1;
      step(1);
      check("run_rise", 32'(running), 1);
      step(3);
      check_val("pre_tick", 12'h600);
      step(1);
      check_val("borrow_chain", 12'h599);

      // Expire from 00.2
      start = 1'b0;
      do_load(4'd0, 4'd0, 4'd2);
      check_val("load_002", 12'h002);
      check("load_idle", 32'(running), 0);
      start = 1'b1;
      step(5);
      check_val("tick_001", 12'h001);
      step(3);
      check_val("hold_001", 12'h001);
      step(1);
      check_val("expire_val", 12'h000);
      check("expire_done", 32'(done_pulse), 1);
      check("expire_at_zero", 32'(at_zero), 1);
      check("expire_running", 32'(running), 0);
      step(1);
      check("done_one_cycle", 32'(done_pulse), 0);
      start = 1'b0; step(1); start = 1'b1; step(5);
      check("expired_ignore_start", 32'(running), 0);
      check_val("expired_hold", 12'h000);
      check("expired_no_done", 32'(done_pulse), 0);

      // Pause keeps prescaler progress
      start = 1'b0;
      do_load(4'd0, 4'd1, 4'd0);
      start = 1'b1;
      step(3);
      check("pause_pre_run", 32'(running), 1);
      start = 1'b0;
      step(10);
      check("paused", 32'(running), 0);
      check_val("paused_val", 12'h010);
      start = 1'b1;
      step(1);
      check("resume", 32'(running), 1);
      step(1);
      check_val("resume_partial", 12'h010);
      step(1);
      check_val("resume_tick", 12'h009);

      // Zero load and clamping
      start = 1'b0;
      do_load(4'd0, 4'd0, 4'd0);
      check("zero_load_at_zero", 32'(at_zero), 1);
      check("zero_load_done", 32'(done_pulse), 0);
      start = 1'b1;
      step(3);
      check("zero_load_running", 32'(running), 0);
      check("zero_load_done2", 32'(done_pulse), 0);
      start = 1'b0;
      do_load(4'd12, 4'd15, 4'd3);
      check_val("clamp", 12'h993);
      check("clamp_at_zero", 32'(at_zero), 0);
      check("clamp_warn", 32'(warn), 0);

      // Load wins over a tick
      start = 1'b1;
      step(4);
      check_val("pre_load_tick", 12'h993);
      load = 1'b1; p_deca = 4'd3; p_sec = 4'd0; p_deci = 4'd0;
      step(1);
      load = 1'b0; start = 1'b0;
      check_val("load_on_tick", 12'h300);
      check("load_on_tick_idle", 32'(running), 0);
      step(1);
      check_val("load_on_tick_hold", 12'h300);

      // Reset mid-run
      start = 1'b1;
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_val("rst_mid_run", 12'h600);
      check("rst_mid_running", 32'(running), 0);
      check("rst_mid_done", 32'(done_pulse), 0);

      // start falls on the tick cycle: decrement suppressed, tick on first RUN cycle after resume
      step(1);
      step(3);
      start = 1'b0;
      step(1);
      check_val("fall_on_tick", 12'h600);
      check("fall_on_tick_idle", 32'(running), 0);
      start = 1'b1;
      step(1);
      check_val("fall_resume_entry", 12'h600);
      step(1);
      check_val("fall_resume_tick", 12'h599);

      // Warning window from 05.1 down to 00.0
      start = 1'b0;
      do_load(4'd0, 4'd5, 4'd1);
      check("warn_051_load", 32'(warn), 0);
      start = 1'b1;
      step(1);
      check("warn_051_run", 32'(warn), 0);
      for (int t = 50; t >= 0; t--) begin
         step(4);
         v = {4'd0, 4'(t / 10), 4'(t % 10)};
`ifdef COUNTDOWN_WARN_EN
         warn_exp = (t > 0);
`else
         warn_exp = 1'b0;
`endif
         check_val("warn_run_val", v);
         check("warn_run", 32'(warn), 32'(warn_exp));
      end
      check("warn_final_at_zero", 32'(at_zero), 1);
      check("warn_final_done", 32'(done_pulse), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown counterpart to the typing-test `stopwatch`. It loads a BCD preset (decaseconds.seconds.deciseconds, max 99.9 s) and counts down at 10 Hz while `start` is high. At 00.0 it flags expiry, which ends a timed typing round. It sits beside `stopwatch` and drives the same three-digit display path.

## Interface
- `TICK_DIV`, 10_000_000: clock cycles per decisecond (100 MHz clock); ≥2.
- `RESET_DECA`, 6: decaseconds digit loaded by reset (0–9).
- `RESET_SEC`, 0: seconds digit loaded by reset (0–9).
- `RESET_DECI`, 0: deciseconds digit loaded by reset (0–9).
- `WARN_SECONDS`, 5: warning threshold in whole seconds (1–9); used only with the macro.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, **synchronous, active-high**.
- `load` in 1: latch the preset digits this cycle.
- `preset_decaseconds` in 4: BCD preset digit.
- `preset_seconds` in 4: BCD preset digit.
- `preset_deciseconds` in 4: BCD preset digit.
- `start` in 1: level-sensitive run enable; low pauses the count.
- `deciseconds_out` out 4: remaining time, BCD.
- `seconds_out` out 4: remaining time, BCD.
- `decaseconds_out` out 4: remaining time, BCD.
- `running` out 1: high while in RUN.
- `at_zero` out 1: high while remaining time is 00.0.
- `done_pulse` out 1: one-cycle pulse when the countdown reaches 00.0.
- `warn` out 1: low-time warning; tied 0 without the macro.

## Operation
- States:
  - IDLE: loaded or paused.
  - RUN: counting.
  - EXPIRED: value is 00.0.
- Reset:
  - Digits = `RESET_DECA`/`RESET_SEC`/`RESET_DECI`; prescaler = 0.
  - State = IDLE, or EXPIRED if all reset digits are 0.
  - `running`=0, `done_pulse`=0, `warn`=0; `at_zero`=1 only if the reset value is 0.
- Priority per cycle: `rst` > `load` > tick/`start`.
- `load`:
  - Digits take the preset values; any preset digit >9 is clamped to 9.
  - Prescaler clears to 0.
  - Next state is IDLE, or EXPIRED if the loaded value is 00.0. `done_pulse` does not fire.
  - Load during RUN aborts the run the same way.
- IDLE → RUN when `start`=1 and value ≠ 0.
- RUN → IDLE when `start`=0. The prescaler holds its count (pause, not restart).
- In RUN, the prescaler counts 0..`TICK_DIV`-1. Reaching `TICK_DIV`-1 is a tick: the prescaler wraps to 0 and the value decrements by 0.1 s.
- BCD decrement:
  - deci 0 → 9 and borrows from sec.
  - sec 0 → 9 and borrows from deca.
  - Decrement is never applied at 00.0.
- RUN → EXPIRED on the tick that takes 00.1 → 00.0.
- EXPIRED holds until `load` or `rst`; `start` is ignored there.

## Timing
- All outputs are registered.
- `running` rises at the edge that samples `start`=1 in IDLE, and falls at the edge that samples `start`=0.
- From a fresh load, the first decrement occurs at the `TICK_DIV`-th edge after `running` rises.
- Pausing keeps partial prescaler progress. After resume, the next tick needs only the remaining cycles.
- The edge that writes 00.0 also sets `at_zero`=1, `done_pulse`=1 and `running`=0. `done_pulse` clears on the following edge.
- `start` falling on the same cycle as a tick: state goes to IDLE, the decrement is suppressed and the prescaler holds at `TICK_DIV`-1. The tick fires on the first RUN cycle after resume.
- `load` together with a tick: load wins, no decrement.
- `rst` mid-run: reset values appear at the next edge; no `done_pulse`.

## Configuration
- Macro: `COUNTDOWN_WARN_EN`.
- Defined: `warn` is registered high whenever 0 < value ≤ `WARN_SECONDS`.0, i.e. deca=0 and (sec<`WARN_SECONDS` or (sec=`WARN_SECONDS` and deci=0)). `warn` is low at 00.0 and in reset. It updates on the same edge as the digits.
- Undefined: no comparator logic is built and `warn` is constant 0.

## Test plan
- Use `TICK_DIV`=4 for all scenarios.
- Reset with defaults → digits 6,0,0; `at_zero`=0; `running`=0; `warn`=0. Hold `start`=1 for 4 cycles → digits 5,9,9 (borrow chain).
- Load 0,0,2 and hold `start`=1 → 00.1 after 4 cycles, 00.0 after 8 cycles. `done_pulse` is high for exactly one cycle, `at_zero`=1, `running`=0. Pulsing `start` afterwards has no effect.
- Load 0,1,0, start, drop `start` after 2 cycles for 10 cycles, then re-raise → the first decrement lands 2 cycles after re-raise; value 00.9.
- Load 0,0,0 → `at_zero`=1, `done_pulse` never asserts, `start`=1 leaves `running`=0. Load 12,15,3 → digits clamp to 9,9,3.
- `load` asserted on a tick cycle during RUN with preset 3,0,0 → digits 3,0,0, state IDLE, no decrement. `rst` mid-run → 6,0,0 next cycle.
- With `COUNTDOWN_WARN_EN` and `WARN_SECONDS`=5: load 0,5,1 and run → `warn` 0 at 05.1, 1 at 05.0, stays 1 down to 00.1, 0 at 00.0. Without the macro, `warn` is always 0.
